i2c_txn_arbiter: RTL and testbench
==================================

Name: i2c_txn_arbiter

Overview:
- Sequences and shares the I2C master (SDA/SCL blocks) between two requesters (index 0 and 1).
- Grants the bus round-robin, latches the winning command, drives the master's start/slave_a/r_w/data/altre_byte inputs byte by byte, and collects read bytes.
- Reports completion and status to the granted requester once the master's stop condition is seen.
- Sits between the system-side command sources and the I2C master.

Parameters:
- TO_CYCLES, 16'd4095, watchdog limit in clk cycles per byte phase; expiry aborts the transaction.
- MAX_LEN, 3'd4, maximum byte count per transaction; len range is 1..MAX_LEN.

Ports:
- clk  in  1  master clock
- reset  in  1  asynchronous, active-low
- req0, req1  in  1  level request; held until matching done pulse
- addr0, addr1  in  7  7-bit slave address
- rw0, rw1  in  1  0 = write, 1 = read
- len0, len1  in  3  byte count, 1..4
- wdata0, wdata1  in  32  write bytes; byte 0 in [31:24], sent first
- done0, done1  out  1  one-cycle completion pulse
- err  out  2  status, valid with done: 00 ok, 01 address NACK, 10 data NACK, 11 timeout or bad len
- rdata  out  32  read bytes; first received byte in [31:24]; unused low bytes 0; valid with done
- gnt  out  2  one-hot current owner; 00 when idle
- m_start  out  1  start request to master
- m_slave_a  out  7  slave address to master
- m_r_w  out  1  direction to master
- m_data  out  8  current write byte to master
- m_altre_byte  out  1  high while more bytes follow the current one
- m_byte_done  in  1  one-cycle pulse after each data-byte ACK slot
- m_nack  in  1  one-cycle pulse: slave NACK; m_phase tells which slot
- m_phase  in  1  0 = address slot, 1 = data slot; qualifies m_nack
- m_rd_byte  in  8  received byte, valid with m_byte_done when m_r_w = 1
- m_stop  in  1  master stop_cond level

Behaviour:
- Reset values: all outputs 0. Round-robin pointer = requester 0. State IDLE.
- States: IDLE, GRANT, START, XFER, STOP_WAIT, DONE.
- IDLE:
  - Pick a requester among active reqs: the pointer's requester has priority; on a tie the other loses.
  - Go to GRANT the next cycle.
- GRANT (1 cycle):
  - Latch addr, rw, len and wdata of the winner. Set gnt. Load byte index to 0 and remaining count to len.
  - If len = 0 or len > MAX_LEN: go to DONE with err = 11. No master activity.
- START:
  - Drive m_start = 1, m_slave_a, m_r_w.
  - m_data = wdata byte 0. m_altre_byte = (remaining > 1).
  - Move to XFER on the first cycle m_stop = 0 after asserting m_start.
- XFER:
  - Deassert m_start.
  - On each m_byte_done:
    - If reading, store m_rd_byte at the index position.
    - Increment index and decrement remaining.
    - Update m_data to the next wdata byte and m_altre_byte = (new remaining > 1), both in the same cycle.
  - When remaining reaches 0: go to STOP_WAIT.
  - m_nack with m_phase = 0: err = 01. With m_phase = 1: err = 10. Go to STOP_WAIT either way.
  - m_nack and m_byte_done in the same cycle: the NACK wins and the byte is not stored.
- STOP_WAIT:
  - Wait for m_stop = 1, then go to DONE.
- DONE (1 cycle):
  - Pulse the granted done. Drive err and rdata.
  - Flip the pointer to the other requester. Clear gnt the next cycle. Return to IDLE.
- Watchdog:
  - Counter clears on entering START, on each m_byte_done, and on entering STOP_WAIT.
  - If it reaches TO_CYCLES in START, XFER or STOP_WAIT: err = 11, force m_altre_byte = 0, go to DONE.
- Requester rules:
  - A requester dropping req mid-transaction has no effect; the transaction completes.
  - A requester keeping req high after done is re-arbitrated normally. Round-robin guarantees alternation when both are active.
- Latency:
  - req to m_start = 3 cycles (IDLE sample, GRANT, START).
  - m_stop to done = 2 cycles.
- rdata and err hold their last values until the next DONE.
- Reset mid-operation: immediate return to reset values. The master is reset by the same net.

Test Plan:
- req0, addr 7'h50, rw 0, len 2, wdata 32'hA55A_0000; bench ACKs every slot.
  - m_start 3 cycles after req0.
  - m_data A5 with altre 1, then 5A with altre 0.
  - done0 with err 00.
- req1, rw 1, len 3; bench returns bytes 11, 22, 33 -> done1, rdata 32'h1122_3300, err 00.
- req0 and req1 asserted in the same cycle after reset, both held.
  - Grants in order 0, 1, 0.
  - gnt is never 11.
- m_nack with m_phase 0 right after START -> err 01, no m_byte_done consumed, done after m_stop.
- Second byte NACKed with m_phase 1 -> err 10. Separately, len 0 -> done in DONE 2 cycles after GRANT, err 11, m_start never high.
- Bench withholds m_byte_done beyond TO_CYCLES -> err 11, m_altre_byte 0. Then assert reset mid-XFER -> all outputs 0 the same cycle.

Source files
------------

// File: rtl/i2c_txn_arbiter_if.sv
// Signals between the two command requesters, the transaction arbiter and the I2C master.
// slave: the arbiter's view; master: the environment (requesters plus I2C master).
interface i2c_txn_arbiter_if;
  logic        req0, req1;
  logic [6:0]  addr0, addr1;
  logic        rw0, rw1;
  logic [2:0]  len0, len1;
  logic [31:0] wdata0, wdata1;
  logic        done0, done1;
  logic [1:0]  err;
  logic [31:0] rdata;
  logic [1:0]  gnt;
  logic        m_start;
  logic [6:0]  m_slave_a;
  logic        m_r_w;
  logic [7:0]  m_data;
  logic        m_altre_byte;
  logic        m_byte_done;
  logic        m_nack;
  logic        m_phase;
  logic [7:0]  m_rd_byte;
  logic        m_stop;

  modport slave (
    input  req0, req1, addr0, addr1, rw0, rw1, len0, len1, wdata0, wdata1,
    input  m_byte_done, m_nack, m_phase, m_rd_byte, m_stop,
    output done0, done1, err, rdata, gnt,
    output m_start, m_slave_a, m_r_w, m_data, m_altre_byte
  );

  modport master (
    output req0, req1, addr0, addr1, rw0, rw1, len0, len1, wdata0, wdata1,
    output m_byte_done, m_nack, m_phase, m_rd_byte, m_stop,
    input  done0, done1, err, rdata, gnt,
    input  m_start, m_slave_a, m_r_w, m_data, m_altre_byte
  );
endinterface

// File: rtl/i2c_txn_arbiter.sv
// Round-robin sharing of one I2C master between two requesters: grants, sequences the
// bytes of the winning command, collects read data and reports status on completion.
module i2c_txn_arbiter #(
  parameter logic [15:0] TO_CYCLES = 16'd4095,
  parameter logic [2:0]  MAX_LEN   = 3'd4
) (
  input  logic            clk,
  input  logic            reset,
  i2c_txn_arbiter_if.slave bus
);

  typedef enum logic [2:0] {IDLE, GRANT, START, XFER, STOP_WAIT, DONE} state_t;

  state_t      state, state_nx;
  logic        ptr, owner, win, any_req, busy, wd_hit, bad_len;
  logic [1:0]  gnt_q, err_q, err_w;
  logic [31:0] rdata_q, rd_buf, wdata_q;
  logic [6:0]  addr_q;
  logic        rw_q;
  logic [2:0]  idx, rem;
  logic [15:0] wd_cnt;
  logic [6:0]  sel_addr;
  logic        sel_rw;
  logic [2:0]  sel_len;
  logic [31:0] sel_wdata;
  logic [7:0]  cur_byte;

  // The pointer's requester wins when it is asking; otherwise the other one does.
  function automatic logic pick(input logic p, input logic r0, input logic r1);
    logic rp;
    rp = p ? r1 : r0;
    return rp ? p : ~p;
  endfunction

  function automatic logic [7:0] byte_at(input logic [31:0] w, input logic [1:0] i);
    case (i)
      2'd0:    return w[31:24];
      2'd1:    return w[23:16];
      2'd2:    return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

  assign any_req   = bus.req0 | bus.req1;
  assign win       = pick(ptr, bus.req0, bus.req1);
  assign sel_addr  = owner ? bus.addr1  : bus.addr0;
  assign sel_rw    = owner ? bus.rw1    : bus.rw0;
  assign sel_len   = owner ? bus.len1   : bus.len0;
  assign sel_wdata = owner ? bus.wdata1 : bus.wdata0;
  assign bad_len   = (sel_len == 3'd0) || (sel_len > MAX_LEN);
  assign wd_hit    = (wd_cnt == TO_CYCLES);
  assign busy      = (state inside {START, XFER, STOP_WAIT});
  assign cur_byte  = byte_at(wdata_q, idx[1:0]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:      if (any_req) state_nx = GRANT;
      GRANT:     state_nx = bad_len ? DONE : START;
      START:     if (!bus.m_stop) state_nx = XFER;
                 else if (wd_hit) state_nx = DONE;
      XFER:      if (bus.m_nack) state_nx = STOP_WAIT;
                 else if (bus.m_byte_done) begin
                   if (rem == 3'd1) state_nx = STOP_WAIT;
                 end
                 else if (wd_hit) state_nx = DONE;
      STOP_WAIT: if (bus.m_stop || wd_hit) state_nx = DONE;
      DONE:      state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr     <= 1'b0;
      owner   <= 1'b0;
      gnt_q   <= 2'b00;
      err_q   <= 2'b00;
      err_w   <= 2'b00;
      rdata_q <= 32'd0;
      rd_buf  <= 32'd0;
      idx     <= 3'd0;
      rem     <= 3'd0;
      wd_cnt  <= 16'd0;
    end else begin
      if (state == IDLE && any_req) begin
        owner <= win;
        gnt_q <= win ? 2'b10 : 2'b01;
      end
      if (state == GRANT) begin
        idx    <= 3'd0;
        rem    <= sel_len;
        err_w  <= 2'b00;
        rd_buf <= 32'd0;
      end
      // A NACK in the same cycle as a byte strobe discards that byte.
      if (state == XFER) begin
        if (bus.m_nack) begin
          err_w <= bus.m_phase ? 2'b10 : 2'b01;
        end else if (bus.m_byte_done) begin
          if (rw_q) rd_buf <= rd_buf | ({bus.m_rd_byte, 24'd0} >> {idx, 3'b000});
          idx <= idx + 3'd1;
          rem <= rem - 3'd1;
        end
      end
      if ((state_nx == START && state != START) ||
          (state_nx == STOP_WAIT && state != STOP_WAIT) ||
          (state == XFER && bus.m_byte_done)) begin
        wd_cnt <= 16'd0;
      end else if (busy && !wd_hit) begin
        wd_cnt <= wd_cnt + 16'd1;
      end
      // Only a clean stop keeps the collected status; every other path into DONE is an abort.
      if (state_nx == DONE && state != DONE) begin
        err_q   <= (state == STOP_WAIT && bus.m_stop) ? err_w : 2'b11;
        rdata_q <= rd_buf;
      end
      if (state == DONE) begin
        ptr   <= ~owner;
        gnt_q <= 2'b00;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == GRANT) begin
      addr_q  <= sel_addr;
      rw_q    <= sel_rw;
      wdata_q <= sel_wdata;
    end
  end

  assign bus.m_start      = (state == START);
  assign bus.m_slave_a    = busy ? addr_q : 7'd0;
  assign bus.m_r_w        = busy & rw_q;
  assign bus.m_data       = busy ? cur_byte : 8'd0;
  assign bus.m_altre_byte = (state == START || state == XFER) && (rem > 3'd1);
  assign bus.done0        = (state == DONE) && !owner;
  assign bus.done1        = (state == DONE) && owner;
  assign bus.err          = err_q;
  assign bus.rdata        = rdata_q;
  assign bus.gnt          = gnt_q;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Randomised scoreboard bench for i2c_txn_arbiter with a behavioural I2C master model.
module tb_i2c_txn_arbiter;
  localparam int TO = 4095;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  i2c_txn_arbiter_if bus();
  i2c_txn_arbiter dut (.clk(clk), .reset(reset), .bus(bus));

  // kind: 0 clean, 1 address NACK, 2 data NACK at fail_at, 3 withheld byte at fail_at
  typedef struct {
    logic        who;
    logic [6:0]  addr;
    logic        rw;
    logic [2:0]  len;
    logic [31:0] wdata;
    logic [31:0] rbytes;
    int          kind;
    int          fail_at;
  } plan_t;

  typedef struct {
    logic        who;
    logic [1:0]  err;
    logic [31:0] rdata;
  } exp_t;

  plan_t bfm_q[$];
  exp_t  exp_q[$];
  int    errors = 0;
  int    checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, want);
    end
  endtask

  function automatic logic [7:0] nth(input logic [31:0] w, input int i);
    return 8'((w >> (24 - 8 * i)) & 32'hFF);
  endfunction

  function automatic plan_t mk(input logic who, input logic [6:0] addr, input logic rw,
                               input logic [2:0] len, input logic [31:0] wdata,
                               input logic [31:0] rbytes, input int kind, input int fail_at);
    plan_t p;
    p.who = who; p.addr = addr; p.rw = rw; p.len = len;
    p.wdata = wdata; p.rbytes = rbytes; p.kind = kind; p.fail_at = fail_at;
    return p;
  endfunction

  // Reference: status from the outcome, rdata from the bytes actually accepted before it.
  function automatic exp_t model(input plan_t p);
    exp_t e;
    int   n;
    e.who = p.who;
    e.rdata = 32'd0;
    if (p.len == 3'd0 || p.len > 3'd4) begin
      e.err = 2'b11;
      return e;
    end
    case (p.kind)
      0:       begin e.err = 2'b00; n = int'(p.len); end
      1:       begin e.err = 2'b01; n = 0; end
      2:       begin e.err = 2'b10; n = p.fail_at; end
      default: begin e.err = 2'b11; n = p.fail_at; end
    endcase
    if (p.rw)
      for (int i = 0; i < n; i++)
        e.rdata = e.rdata | ({24'd0, nth(p.rbytes, i)} << (24 - 8 * i));
    return e;
  endfunction

  function automatic logic [63:0] outs();
    return 64'({bus.done0, bus.done1, bus.err, bus.rdata, bus.gnt, bus.m_start,
                bus.m_slave_a, bus.m_r_w, bus.m_data, bus.m_altre_byte});
  endfunction

  task automatic summary();
    $display("Result: errors=%0d of %0d checks", errors, checks);
  endtask

  task automatic pulse_nack(input logic ph);
    bus.m_nack = 1'b1;
    bus.m_phase = ph;
    @(negedge clk);
    bus.m_nack = 1'b0;
    bus.m_phase = 1'b0;
  endtask

  // I2C master model serving one planned transaction from the cycle m_start is seen.
  task automatic serve(input plan_t p);
    check("start_addr", 64'(bus.m_slave_a), 64'(p.addr));
    check("start_rw", 64'(bus.m_r_w), 64'(p.rw));
    if (!p.rw) check("start_data", 64'(bus.m_data), 64'(nth(p.wdata, 0)));
    check("start_altre", 64'(bus.m_altre_byte), 64'(p.len > 3'd1));
    bus.m_stop = 1'b0;
    for (int i = 0; i < int'(p.len); i++) begin
      repeat ($urandom_range(1, 3)) @(negedge clk);
      if (p.kind == 1 && i == 0) begin pulse_nack(1'b0); break; end
      if (p.kind == 2 && i == p.fail_at) begin pulse_nack(1'b1); break; end
      if (p.kind == 3 && i == p.fail_at) begin
        int k;
        k = 0;
        while (reset && !(bus.done0 || bus.done1) && k < TO + 64) begin
          @(negedge clk);
          k++;
        end
        if (reset) begin
          if (k >= TO + 64) check("timeout_done_seen", 64'd0, 64'd1);
          else check("timeout_altre", 64'(bus.m_altre_byte), 64'd0);
        end
        bus.m_stop = 1'b1;
        return;
      end
      if (!p.rw) check("byte_data", 64'(bus.m_data), 64'(nth(p.wdata, i)));
      check("byte_altre", 64'(bus.m_altre_byte), 64'((int'(p.len) - i) > 1));
      bus.m_rd_byte = nth(p.rbytes, i);
      bus.m_byte_done = 1'b1;
      @(negedge clk);
      bus.m_byte_done = 1'b0;
    end
    repeat ($urandom_range(1, 3)) @(negedge clk);
    bus.m_stop = 1'b1;
    @(negedge clk);
    check("stop_to_done", 64'(bus.done0 | bus.done1), 64'd1);
  endtask

  initial begin
    plan_t p;
    bus.m_byte_done = 1'b0; bus.m_nack = 1'b0; bus.m_phase = 1'b0;
    bus.m_rd_byte = 8'd0;   bus.m_stop = 1'b1;
    forever begin
      @(negedge clk);
      if (reset && bus.m_start) begin
        if (bfm_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_start: got m_start 1, want 0");
        end else begin
          p = bfm_q.pop_front();
          serve(p);
        end
      end
    end
  end

  // Scoreboard monitor: every done pulse is matched against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset && (bus.done0 || bus.done1)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done %b%b, want none", bus.done1, bus.done0);
        end else begin
          e = exp_q.pop_front();
          check("done_owner", 64'({bus.done1, bus.done0}), e.who ? 64'd2 : 64'd1);
          check("done_gnt", 64'(bus.gnt), e.who ? 64'd2 : 64'd1);
          check("done_err", 64'(bus.err), 64'(e.err));
          check("done_rdata", 64'(bus.rdata), 64'(e.rdata));
        end
      end
    end
  end

  task automatic drive(input plan_t p);
    if (!p.who) begin
      bus.addr0 = p.addr; bus.rw0 = p.rw; bus.len0 = p.len; bus.wdata0 = p.wdata;
    end else begin
      bus.addr1 = p.addr; bus.rw1 = p.rw; bus.len1 = p.len; bus.wdata1 = p.wdata;
    end
  endtask

  task automatic issue(input plan_t p);
    if (p.len != 3'd0 && p.len <= 3'd4) bfm_q.push_back(p);
    exp_q.push_back(model(p));
  endtask

  task automatic wait_done(input logic who, input int budget);
    int k;
    k = 0;
    while (!(who ? bus.done1 : bus.done0)) begin
      @(negedge clk);
      k++;
      if (k > budget) begin
        checks++;
        errors++;
        $display("FAIL wait_done%0d: got no done in %0d cycles, want done", who, budget);
        summary();
        $finish;
      end
    end
  endtask

  task automatic set_req(input logic who, input logic v);
    if (who) bus.req1 = v;
    else     bus.req0 = v;
  endtask

  task automatic run_txn(input plan_t p);
    @(negedge clk);
    drive(p);
    issue(p);
    set_req(p.who, 1'b1);
    wait_done(p.who, (p.kind == 3) ? TO + 200 : 200);
    set_req(p.who, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", outs(), 64'd0);
    reset = 1'b1;
  endtask

  initial begin
    plan_t p, pa, pb;
    int    lat, r;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.addr0 = 7'd0; bus.addr1 = 7'd0; bus.rw0 = 1'b0; bus.rw1 = 1'b0;
    bus.len0 = 3'd0; bus.len1 = 3'd0; bus.wdata0 = 32'd0; bus.wdata1 = 32'd0;
    do_reset();

    // Write of two bytes; m_start should be up in the third cycle of req0.
    p = mk(1'b0, 7'h50, 1'b0, 3'd2, 32'hA55A_0000, 32'd0, 0, 0);
    @(negedge clk);
    drive(p);
    issue(p);
    bus.req0 = 1'b1;
    lat = 1;
    while (!bus.m_start && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("req_to_start", 64'(lat), 64'd3);
    wait_done(1'b0, 200);
    bus.req0 = 1'b0;

    run_txn(mk(1'b1, 7'h51, 1'b1, 3'd3, 32'd0, 32'h1122_3300, 0, 0));

    // Both requesters from reset: expected grant order 0, 1, 0.
    do_reset();
    @(negedge clk);
    pa = mk(1'b0, 7'h21, 1'b0, 3'd1, 32'hC300_0000, 32'd0, 0, 0);
    pb = mk(1'b1, 7'h42, 1'b1, 3'd2, 32'd0, 32'h9876_0000, 0, 0);
    drive(pa);
    drive(pb);
    issue(pa);
    issue(pb);
    issue(pa);
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    wait_done(1'b0, 200);
    wait_done(1'b1, 200);
    bus.req1 = 1'b0;
    wait_done(1'b0, 200);
    bus.req0 = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_gnt", 64'(bus.gnt), 64'd0);

    run_txn(mk(1'b1, 7'h33, 1'b0, 3'd2, 32'hDEAD_0000, 32'd0, 1, 0));
    run_txn(mk(1'b0, 7'h34, 1'b0, 3'd3, 32'h0102_0300, 32'd0, 2, 1));
    run_txn(mk(1'b0, 7'h10, 1'b0, 3'd0, 32'hFFFF_FFFF, 32'd0, 0, 0));
    run_txn(mk(1'b1, 7'h55, 1'b0, 3'd3, 32'h1122_3344, 32'd0, 3, 1));

    for (int t = 0; t < 24; t++) begin
      p.who    = 1'($urandom_range(0, 1));
      p.addr   = 7'($urandom_range(0, 127));
      p.rw     = 1'($urandom_range(0, 1));
      p.wdata  = $urandom;
      p.rbytes = $urandom;
      p.len    = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(1, 4));
      r = int'($urandom_range(0, 9));
      p.kind    = (r < 6 || p.len > 3'd4) ? 0 : (r < 8) ? 1 : 2;
      p.fail_at = (p.len > 3'd4) ? 0 : int'($urandom_range(0, int'(p.len) - 1));
      run_txn(p);
    end

    // Reset in the middle of a byte phase.
    @(negedge clk);
    p = mk(1'b0, 7'h2A, 1'b0, 3'd2, 32'h6699_0000, 32'd0, 3, 1);
    drive(p);
    bfm_q.push_back(p);
    bus.req0 = 1'b1;
    lat = 0;
    while (!bus.m_start && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    repeat (6) @(negedge clk);
    check("pre_reset_gnt", 64'(bus.gnt), 64'd1);
    #2 reset = 1'b0;
    #1 check("reset_mid_xfer", outs(), 64'd0);
    bus.req0 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    summary();
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: got no end of run, want end of run");
    errors++;
    summary();
    $fatal(1, "simulation time limit");
  end

endmodule
